instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder; the inverse of the core's immediate/field decode path.
- Accepts decoded fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake and emits packed 32-bit instruction words.
- Optionally expands an out-of-range load-immediate into a LUI+ADDI pair.
- Used by the self-test program generator and the debug-injection path ahead of instruction memory.

Parameters:
- CHECK_ALIGN, 1: 1 = B/J immediates with imm[0]=1 are flagged ALIGN; 0 = imm[0] silently ignored.
- STAT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  7  instruction opcode[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  signed byte-offset/value; U-type carries the full value with low 12 bits zero
- in_expand  in  1  permit LI expansion
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_instr  out  32  encoded instruction
- out_last  out  1  final word of this request
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 RANGE, 10 ALIGN, 11 OPCODE

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_instr=0, out_last=0, err_valid=0, err_code=0, pending ADDI discarded, state IDLE.
- Format by opcode:
  - 0110111/0010111: U.
  - 1101111: J.
  - 1100111/0000011/0010011: I.
  - 0100011: S.
  - 1100011: B.
  - 0110011: R.
  - Anything else: OPCODE error.
- Immediate placement inverts the standard RV32I scatter: I imm[11:0]→[31:20]; S imm[11:5]→[31:25], imm[4:0]→[11:7]; B imm[12|10:5|4:1|11]; J imm[20|10:1|11|19:12]; U imm[31:12]→[31:12].
- OP-IMM shifts: imm[11:0] is encoded verbatim; the caller supplies funct7 in imm[11:5].
- Range checks on the signed in_imm:
  - I/S: [-2048, 2047].
  - B: [-4096, 4094].
  - J: [-1048576, 1048574].
  - U: imm[11:0] must be 0, else RANGE.
- Error priority: OPCODE > ALIGN > RANGE.
- On error: the request is consumed, err_valid pulses for 1 cycle the cycle after acceptance, and no word is emitted.
- Expansion condition: opcode 0010011, funct3 000, rs1=x0, in_expand=1, and imm outside the I range. Instead of RANGE, emit two words:
  - word 1: LUI rd, hi, with hi=(imm+0x800)>>12 (32-bit wrap), out_last=0.
  - word 2: ADDI rd, rd, lo, with lo=imm[11:0], out_last=1.
- Single-word requests always have out_last=1.
- State machine:
  - IDLE → EMIT on a non-error accept.
  - EMIT → EMIT2 when word 1 of an expansion is handed off.
  - EMIT2 → IDLE/EMIT when the ADDI is handed off.
- Latency and throughput: the word is registered and out_valid rises the cycle after acceptance. Sustained throughput is 1 word/cycle for single-word requests.
- in_ready = !pending_lo && (!out_valid || out_ready). A new request is accepted in the same cycle the previous word drains.
- While out_valid=1 and out_ready=0, out_instr and out_last hold stable.
- A reset asserted mid-expansion drops the pending ADDI and leaves no partial output.

Optional Feature:
- Macro: INSTR_ENCODER_STATS_EN.
- Defined: adds outputs stat_words (STAT_W), incremented per out_valid&&out_ready, and stat_errs (STAT_W), incremented per err_valid. Both saturate at all-ones and clear on reset.
- Undefined: neither port nor counter logic exists.

Test Plan:
- ADDI x5,x6,-1 (opcode 0010011, funct3 000, imm=-1), out_ready=1 → out_instr 0xFFF30293, out_last=1, out_valid one cycle after accept.
- BEQ x1,x2,-4 → 0xFE208EE3. BEQ with imm=3 → err_code 10, no out_valid. JAL with imm=0x100000 → err_code 01.
- LI a0,0x12345FFF with in_expand=1, out_ready low 3 cycles → holds 0x12346537 (out_last=0) stable, then 0xFFF50513 (out_last=1); in_ready=0 throughout.
- Back-to-back ADD x3,x1,x2 ×8 with out_ready toggling 1010… → exactly 8 words of 0x002081B3, no loss or duplication.
- Opcode 1111111 → err_code 11. Assert rst_n=0 while the LUI is pending → out_valid=0 next cycle, no ADDI emitted after reset.
- With INSTR_ENCODER_STATS_EN: after the above sequences, stat_words and stat_errs match the emitted-word and error-pulse counts; forcing STAT_W all-ones confirms saturation.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I field-to-word encoder with optional LUI+ADDI load-immediate expansion.
// Define INSTR_ENCODER_STATS_EN to add saturating stat_words / stat_errs counters.
module instr_encoder #(
    parameter int CHECK_ALIGN = 1,
    parameter int STAT_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_expand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err_valid,
    output logic [1:0]  err_code
`ifdef INSTR_ENCODER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_words,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_t;

    state_t      state_reg, state_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic [31:0] lo_instr_reg, lo_instr_next;
    logic        out_last_reg, out_last_next;
    logic        pending_lo_reg, pending_lo_next;
    logic        err_valid_reg, err_valid_next;
    logic [1:0]  err_code_reg, err_code_next;

    logic fmt_u, fmt_j, fmt_i, fmt_s, fmt_b, fmt_r;
    logic signed [31:0] imm_s;
    logic in_i_range, in_b_range, in_j_range;
    logic bad_opcode, bad_align, bad_range, do_expand;
    logic [1:0]  req_err;
    logic [19:0] lui_hi;
    logic [31:0] enc_word, first_word, addi_word;
    logic        accept, drain;

    always_comb begin
        fmt_u = 1'b0;
        fmt_j = 1'b0;
        fmt_i = 1'b0;
        fmt_s = 1'b0;
        fmt_b = 1'b0;
        fmt_r = 1'b0;
        case (in_opcode)
            OP_LUI, OP_AUIPC:         fmt_u = 1'b1;
            OP_JAL:                   fmt_j = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: fmt_i = 1'b1;
            OP_STORE:                 fmt_s = 1'b1;
            OP_BRANCH:                fmt_b = 1'b1;
            OP_REG:                   fmt_r = 1'b1;
            default:                  ;
        endcase
    end

    assign imm_s      = $signed(in_imm);
    assign in_i_range = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign in_b_range = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
    assign in_j_range = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);

    assign bad_opcode = !(fmt_u || fmt_j || fmt_i || fmt_s || fmt_b || fmt_r);
    assign bad_align  = (CHECK_ALIGN != 0) && (fmt_b || fmt_j) && in_imm[0];
    assign do_expand  = (in_opcode == OP_IMM) && (in_funct3 == 3'b000) && (in_rs1 == 5'd0)
                        && in_expand && !in_i_range;
    assign bad_range  = ((fmt_i || fmt_s) && !in_i_range && !do_expand)
                        || (fmt_b && !in_b_range)
                        || (fmt_j && !in_j_range)
                        || (fmt_u && (in_imm[11:0] != 12'd0));
    assign req_err    = bad_opcode ? 2'b11 : bad_align ? 2'b10 : bad_range ? 2'b01 : 2'b00;

    always_comb begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        if (fmt_u)
            enc_word = {in_imm[31:12], in_rd, in_opcode};
        else if (fmt_j)
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        else if (fmt_i)
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        else if (fmt_s)
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        else if (fmt_b)
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
    end

    // Adding imm[11] to the upper part is (imm + 0x800) >> 12, compensating the sign-extended ADDI.
    assign lui_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    assign addi_word  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
    assign first_word = do_expand ? {lui_hi, in_rd, OP_LUI} : enc_word;

    assign out_valid = (state_reg != IDLE);
    assign in_ready  = !pending_lo_reg && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_next      = state_reg;
        out_instr_next  = out_instr_reg;
        lo_instr_next   = lo_instr_reg;
        out_last_next   = out_last_reg;
        pending_lo_next = pending_lo_reg;
        err_valid_next  = 1'b0;
        err_code_next   = err_code_reg;
        if (drain && pending_lo_reg) begin
            out_instr_next  = lo_instr_reg;
            out_last_next   = 1'b1;
            pending_lo_next = 1'b0;
            state_next      = EMIT2;
        end else begin
            if (drain)
                state_next = IDLE;
            if (accept) begin
                if (req_err != 2'b00) begin
                    err_valid_next = 1'b1;
                    err_code_next  = req_err;
                end else begin
                    out_instr_next  = first_word;
                    out_last_next   = !do_expand;
                    pending_lo_next = do_expand;
                    lo_instr_next   = addi_word;
                    state_next      = EMIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            out_instr_reg  <= 32'd0;
            lo_instr_reg   <= 32'd0;
            out_last_reg   <= 1'b0;
            pending_lo_reg <= 1'b0;
            err_valid_reg  <= 1'b0;
            err_code_reg   <= 2'b00;
        end else begin
            state_reg      <= state_next;
            out_instr_reg  <= out_instr_next;
            lo_instr_reg   <= lo_instr_next;
            out_last_reg   <= out_last_next;
            pending_lo_reg <= pending_lo_next;
            err_valid_reg  <= err_valid_next;
            err_code_reg   <= err_code_next;
        end
    end

    assign out_instr = out_instr_reg;
    assign out_last  = out_last_reg;
    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;

`ifdef INSTR_ENCODER_STATS_EN
    logic [1:0] stat_inc;
    assign stat_inc = {err_valid_reg, drain};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [STAT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt_reg <= '0;
            else if (stat_inc[gi] && (cnt_reg != '1))
                cnt_reg <= cnt_reg + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stat_words = g_stat[0].cnt_reg;
    assign stat_errs  = g_stat[1].cnt_reg;
`endif

endmodule
